// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_bridge
// Purpose  : M-stage bridge from the pipeline data port to RAM and MMIO
//            slaves with address decode, req/ack handshake and error return.
//            Optional BUS_TIMEOUT_EN macro adds a WAIT-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_bridge #(
    parameter logic [31:0] RAM_BASE       = 32'h1000_0000,
    parameter int          RAM_SIZE_LOG2  = 16,
    parameter logic [31:0] IO_BASE        = 32'h2000_0000,
    parameter int          IO_SIZE_LOG2   = 12,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic                     i_we,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_wmask,
    output logic [31:0]              o_rdata,
    output logic                     o_ack,
    output logic                     o_err,
    output logic                     o_ram_req,
    output logic                     o_ram_we,
    output logic [RAM_SIZE_LOG2-1:0] o_ram_addr,
    output logic [31:0]              o_ram_wdata,
    output logic [3:0]               o_ram_wmask,
    input  logic [31:0]              i_ram_rdata,
    input  logic                     i_ram_ack,
    output logic                     o_io_req,
    output logic                     o_io_we,
    output logic [IO_SIZE_LOG2-1:0]  o_io_addr,
    output logic [31:0]              o_io_wdata,
    output logic [3:0]               o_io_wmask,
    input  logic [31:0]              i_io_rdata,
    input  logic                     i_io_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_sel_ram;
    logic                     r_sel_io;
    logic                     r_we;
    logic [RAM_SIZE_LOG2-1:0] r_ram_addr;
    logic [IO_SIZE_LOG2-1:0]  r_io_addr;
    logic [31:0]              r_wdata;
    logic [3:0]               r_wmask;
    logic [31:0]              r_rdata;
    logic                     r_err;

    logic                     w_ram_hit;
    logic                     w_io_hit;
    logic                     w_slave_ack;
    logic [31:0]              w_slave_rdata;
    logic                     w_accept;
    logic                     w_timeout;

    assign w_ram_hit     = (i_addr >> RAM_SIZE_LOG2) == (RAM_BASE >> RAM_SIZE_LOG2);
    assign w_io_hit      = (i_addr >> IO_SIZE_LOG2) == (IO_BASE >> IO_SIZE_LOG2);
    // Acks are qualified by the latched select so a stale ack from the other slave is ignored
    assign w_slave_ack   = (r_sel_ram & i_ram_ack) | (r_sel_io & i_io_ack);
    assign w_slave_rdata = r_sel_ram ? i_ram_rdata : i_io_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_accept) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // Fires on the edge that closes the TIMEOUT_CYCLES-th WAIT cycle
    assign w_timeout = (r_state == S_WAIT) && ((r_tmo_cnt + 16'd1) == c_timeout);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_accept    = w_ram_hit | w_io_hit;
                    w_state_nxt = (w_ram_hit | w_io_hit) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (w_slave_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sel_ram  <= 1'b0;
            r_sel_io   <= 1'b0;
            r_we       <= 1'b0;
            r_ram_addr <= '0;
            r_io_addr  <= '0;
            r_wdata    <= 32'd0;
            r_wmask    <= 4'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_req) begin
                r_sel_ram  <= w_ram_hit;
                r_sel_io   <= w_io_hit & ~w_ram_hit;
                r_we       <= i_we;
                r_ram_addr <= i_addr[RAM_SIZE_LOG2-1:0];
                r_io_addr  <= i_addr[IO_SIZE_LOG2-1:0];
                r_wdata    <= i_wdata;
                r_wmask    <= i_wmask;
                r_rdata    <= 32'd0;
                r_err      <= ~(w_ram_hit | w_io_hit);
            end else if (r_state == S_WAIT) begin
                // Ack takes priority over a coincident timeout
                if (w_slave_ack) begin
                    r_rdata <= r_we ? 32'd0 : w_slave_rdata;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign o_ack       = (r_state == S_RESP);
    assign o_err       = o_ack & r_err;
    assign o_rdata     = o_ack ? r_rdata : 32'd0;

    assign o_ram_req   = (r_state == S_WAIT) & r_sel_ram;
    assign o_ram_we    = r_sel_ram & r_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_sel_ram ? r_wdata : 32'd0;
    assign o_ram_wmask = r_sel_ram ? r_wmask : 4'd0;

    assign o_io_req    = (r_state == S_WAIT) & r_sel_io;
    assign o_io_we     = r_sel_io & r_we;
    assign o_io_addr   = r_io_addr;
    assign o_io_wdata  = r_sel_io ? r_wdata : 32'd0;
    assign o_io_wmask  = r_sel_io ? r_wmask : 4'd0;

endmodule
`default_nettype wire
